// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
// - phase_t   : game phase encoding, also driven out on the phase port
// - LEVEL_MAX : highest difficulty level
// - mole_life : mole lifetime in ticks for a given level, floored at a minimum
package game_pkg;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        Countdown = 2'd1,
        Play      = 2'd2,
        Done      = 2'd3
    } phase_t;

    localparam int unsigned LEVEL_MAX = 7;

    // max(init - lvl*step, floor_v) without letting the subtraction wrap
    function automatic int unsigned mole_life(input int unsigned lvl,
                                              input int unsigned init,
                                              input int unsigned step,
                                              input int unsigned floor_v);
        int unsigned dec;
        dec = lvl * step;
        if (dec + floor_v >= init) begin
            return floor_v;
        end
        return init - dec;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick generator: divides clk by TICK_DIV.
// Ports:
// - clk   : system clock
// - rst_n : synchronous active-low reset
// - clr   : restart the division so the next tick is a full period away
// - tick  : 1-cycle pulse on the last cycle of each period
module tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = $clog2(TICK_DIV + 1);

    logic [CntW-1:0] cnt;

    assign tick = (cnt == CntW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the whack-a-mole game: owns the game phase, the game
// clock, the per-mole lifetime and the difficulty level.
// Ports:
// - clk, rst_n    : clock, synchronous active-low reset
// - start         : debounced start button (level; only rising edges act)
// - hit           : 1-cycle pulse, current mole was hit
// - spawn         : 1-cycle pulse, mole FSM must pick a new mole
// - mole_expired  : 1-cycle pulse, current mole timed out unhit
// - phase         : 0 idle, 1 countdown, 2 play, 3 done
// - game_active   : high in play
// - game_end      : high in done
// - cd_digit      : remaining countdown digit, 0 outside countdown
// - level         : current difficulty level
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned CD_STEPS      = 3,
    parameter int unsigned CD_STEP_TICKS = 1000,
    parameter int unsigned GAME_TICKS    = 15000,
    parameter int unsigned MOLE_INIT     = 1500,
    parameter int unsigned MOLE_STEP     = 150,
    parameter int unsigned MOLE_MIN      = 300,
    parameter int unsigned HITS_PER_LVL  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    output logic       spawn,
    output logic       mole_expired,
    output logic [1:0] phase,
    output logic       game_active,
    output logic       game_end,
    output logic [1:0] cd_digit,
    output logic [2:0] level
);

    localparam int unsigned CdW   = $clog2(CD_STEP_TICKS + 1);
    localparam int unsigned GameW = $clog2(GAME_TICKS + 1);
    localparam int unsigned MoleW = $clog2(MOLE_INIT + 1);
    localparam int unsigned HitW  = $clog2(HITS_PER_LVL + 1);

    localparam logic [1:0] CdInit   = 2'(CD_STEPS);
    localparam logic [2:0] LevelTop = 3'(LEVEL_MAX);

    phase_t            state;
    logic              start_q;
    logic              start_rise_q;
    logic [CdW-1:0]    cd_cnt;
    logic [GameW-1:0]  game_cnt;
    logic [MoleW-1:0]  mole_tmr;
    logic [HitW-1:0]   hit_cnt;

    logic              tick;
    logic              phase_chg;
    logic              cd_step;
    logic              game_over;
    logic              mole_out;
    logic              hit_wrap;
    logic [2:0]        level_nxt;
    logic [MoleW-1:0]  life_cur;
    logic [MoleW-1:0]  life_nxt;

    // Cleared on the same edge the phase changes, so every phase opens with
    // a full tick period.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_chg),
        .tick  (tick)
    );

    assign phase       = state;
    assign game_active = (state == Play);
    assign game_end    = (state == Done);

    assign cd_step   = tick && (cd_cnt == CdW'(CD_STEP_TICKS - 1));
    assign game_over = tick && (game_cnt == GameW'(GAME_TICKS - 1));
    // The tick that would take the timer to zero ends the mole's life.
    assign mole_out  = tick && (mole_tmr <= MoleW'(1));
    assign hit_wrap  = (hit_cnt == HitW'(HITS_PER_LVL - 1));

    always_comb begin
        level_nxt = level;
        if (hit && hit_wrap && (level != LevelTop)) begin
            level_nxt = level + 3'd1;
        end
        life_cur = MoleW'(mole_life(32'(level), MOLE_INIT, MOLE_STEP, MOLE_MIN));
        life_nxt = MoleW'(mole_life(32'(level_nxt), MOLE_INIT, MOLE_STEP, MOLE_MIN));

        phase_chg = 1'b0;
        unique case (state)
            Idle:      phase_chg = start_rise_q;
            Countdown: phase_chg = cd_step && (cd_digit == 2'd1);
            Play:      phase_chg = game_over;
            Done:      phase_chg = start_rise_q;
            default:   phase_chg = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= Idle;
            // Sampling start here keeps a button held through reset from
            // looking like a fresh press afterwards.
            start_q      <= start;
            start_rise_q <= 1'b0;
            cd_cnt       <= '0;
            game_cnt     <= '0;
            mole_tmr     <= '0;
            hit_cnt      <= '0;
            level        <= '0;
            cd_digit     <= '0;
            spawn        <= 1'b0;
            mole_expired <= 1'b0;
        end else begin
            start_q      <= start;
            start_rise_q <= start & ~start_q;
            spawn        <= 1'b0;
            mole_expired <= 1'b0;

            unique case (state)
                Idle, Done: begin
                    if (start_rise_q) begin
                        state    <= Countdown;
                        cd_digit <= CdInit;
                        cd_cnt   <= '0;
                        hit_cnt  <= '0;
                        level    <= '0;
                    end
                end

                Countdown: begin
                    if (cd_step) begin
                        cd_cnt <= '0;
                        if (cd_digit == 2'd1) begin
                            state    <= Play;
                            cd_digit <= '0;
                            game_cnt <= '0;
                            spawn    <= 1'b1;
                            mole_tmr <= life_cur;
                        end else begin
                            cd_digit <= cd_digit - 2'd1;
                        end
                    end else if (tick) begin
                        cd_cnt <= cd_cnt + CdW'(1);
                    end
                end

                Play: begin
                    // A hit always counts, even on the closing tick.
                    if (hit) begin
                        hit_cnt <= hit_wrap ? '0 : hit_cnt + HitW'(1);
                        level   <= level_nxt;
                    end
                    if (tick) begin
                        game_cnt <= game_cnt + GameW'(1);
                    end
                    if (game_over) begin
                        state <= Done;
                    end else if (hit) begin
                        spawn    <= 1'b1;
                        mole_tmr <= life_nxt;
                    end else if (mole_out) begin
                        spawn        <= 1'b1;
                        mole_expired <= 1'b1;
                        mole_tmr     <= life_cur;
                    end else if (tick) begin
                        mole_tmr <= mole_tmr - MoleW'(1);
                    end
                end

                default: state <= Idle;
            endcase
        end
    end

endmodule
